// File: rtl/tone_period_meter_pkg.sv
// ============================================================================
// tone_period_meter_pkg : shared state encoding and default width
// Rev 1.0
// ============================================================================
`default_nettype none

package tone_period_meter_pkg;

  localparam int c_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/tone_period_meter_edge_sync.sv
// ============================================================================
// tone_edge_sync : two-flop synchroniser plus history flop, rising-edge pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module tone_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic i_Async,
  output logic o_Rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= i_Async;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign o_Rise = r_sync2 & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/tone_period_meter.sv
// ============================================================================
// tone_period_meter : measures rising-to-rising period of an async tone
// Rev 1.0
// ============================================================================
`default_nettype none

module tone_period_meter
  import tone_period_meter_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_Enable,
  input  logic             i_Tone,
  output logic [WIDTH-1:0] o_Period,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic             o_Overrun,
  output logic             o_Timeout
);

  localparam logic [WIDTH-1:0] c_COUNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_COUNT_MAX = '1;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_valid;
  logic             r_overrun;
  logic             r_timeout;

  logic             w_rise;
  logic             w_capture;

  tone_edge_sync u_edge_sync (
    .clock   (clock),
    .reset   (reset),
    .i_Async (i_Tone),
    .o_Rise  (w_rise)
  );

  // Gating with i_Enable drops any edge coincident with the enable falling.
  assign w_capture = i_Enable && (r_state == MEASURE) && w_rise;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_period  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (!i_Enable) begin
        r_state   <= IDLE;
        r_count   <= '0;
        r_overrun <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ARM;
          end
          ARM: begin
            if (w_rise) begin
              r_state <= MEASURE;
              r_count <= c_COUNT_ONE;
            end
          end
          MEASURE: begin
            if (w_rise) begin
              r_count <= c_COUNT_ONE;
            end else if (r_count == c_COUNT_MAX) begin
              // Saturated without an edge: abandon this period and re-arm.
              r_timeout <= 1'b1;
              r_count   <= '0;
              r_state   <= ARM;
            end else begin
              r_count <= r_count + c_COUNT_ONE;
            end
          end
          default: begin
            r_state <= IDLE;
            r_count <= '0;
          end
        endcase
      end

      // A capture may replace the held result only if it is consumed this cycle.
      if (w_capture) begin
        if (!r_valid || i_Ready) begin
          r_period  <= r_count;
          r_valid   <= 1'b1;
          r_timeout <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_Period  = r_period;
  assign o_Valid   = r_valid;
  assign o_Overrun = r_overrun;
  assign o_Timeout = r_timeout;

endmodule

`default_nettype wire
